// File: rtl/instr_encoder.sv
// instr_encoder: MIPS R/I/J instruction encoder feeding a 2-entry output FIFO.
// Define MIPS_CRYPT_EN to make R-type functs 30/31 legal.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic        err_seen
);
  logic        w_shift_imm, w_crypt, w_r_legal, w_i_legal, w_j_legal, w_err;
  logic [31:0] w_r_word, w_i_word, w_j_word, w_word;
  logic        w_push, w_pop;
  logic [1:0]  w_wpos;
  logic [32:0] w_entry;
  logic [1:0]  r_cnt;
  logic [32:0] r_q0, r_q1;
  logic [15:0] r_enc_count;
  logic        r_err_seen;
  assign w_shift_imm = in_funct inside {6'h00, 6'h02, 6'h03, 6'h1C, 6'h1D};
`ifdef MIPS_CRYPT_EN
  assign w_crypt = in_funct inside {6'h30, 6'h31};
`else
  assign w_crypt = 1'b0;
`endif
  assign w_r_legal = (in_opcode == 6'h00) && (w_crypt || in_funct inside {6'h20, 6'h22, 6'h18,
    6'h24, 6'h26, 6'h25, 6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h1C, 6'h1D, 6'h1E,
    6'h1F, 6'h2A, 6'h2B, 6'h08, 6'h09});
  assign w_i_legal = in_opcode inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h23,
    6'h2B, 6'h04, 6'h05, 6'h01, 6'h07};
  assign w_j_legal = in_opcode inside {6'h02, 6'h03};
  // jr drops rt/rd, jalr drops rt; immediate shifts take shamt from imm and drop rs
  assign w_r_word = {6'h00, w_shift_imm ? 5'd0 : in_rs,
                     (in_funct inside {6'h08, 6'h09}) ? 5'd0 : in_rt,
                     (in_funct == 6'h08) ? 5'd0 : in_rd,
                     w_shift_imm ? in_imm[4:0] : 5'd0, in_funct};
  assign w_i_word = {in_opcode, (in_opcode == 6'h0F) ? 5'd0 : in_rs,
                     (in_opcode inside {6'h01, 6'h07}) ? 5'd0 : in_rt, in_imm};
  assign w_j_word = {in_opcode, in_target};
  assign w_word = w_r_legal ? w_r_word : w_i_legal ? w_i_word : w_j_legal ? w_j_word : 32'h0;
  assign w_err = !(w_r_legal || w_i_legal || w_j_legal);
  assign w_entry = {w_err, w_word};
  assign in_ready = r_cnt != 2'd2;
  assign out_valid = r_cnt != 2'd0;
  assign w_push = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;
  assign w_wpos = r_cnt - {1'b0, w_pop};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_q0 <= '0;
      r_q1 <= '0;
      r_enc_count <= 16'd0;
      r_err_seen <= 1'b0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) r_q0 <= r_q1;
      if (w_push && w_wpos == 2'd0) r_q0 <= w_entry;
      if (w_push && w_wpos == 2'd1) r_q1 <= w_entry;
      if (w_pop) r_enc_count <= r_enc_count + 16'd1;
      if (w_push && w_err) r_err_seen <= 1'b1;
    end
  end
  assign out_word = out_valid ? r_q0[31:0] : 32'h0;
  assign out_err = out_valid && r_q0[32];
  assign enc_count = r_enc_count;
  assign err_seen = r_err_seen;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random stimulus against a queue-based reference model.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic        out_err;
  logic [15:0] enc_count;
  logic        err_seen;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_err(out_err), .enc_count(enc_count), .err_seen(err_seen)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [32:0] m_q[$];
  int m_count = 0;
  bit m_err_seen = 0;

  function automatic logic [32:0] ref_enc(input logic [5:0] op, f, input logic [4:0] rs, rt, rd,
                                          input logic [15:0] imm, input logic [25:0] tg);
    logic [31:0] rsv = 32'(rs), rtv = 32'(rt), rdv = 32'(rd), sh = 0, w = 0;
    bit ok = 0;
    if (op == 0) begin
      ok = f inside {'h20, 'h22, 'h18, 'h24, 'h26, 'h25, 'h27, 'h00, 'h02, 'h03, 'h04, 'h06,
                     'h07, 'h1C, 'h1D, 'h1E, 'h1F, 'h2A, 'h2B, 'h08, 'h09};
`ifdef MIPS_CRYPT_EN
      ok = ok || (f inside {'h30, 'h31});
`endif
      if (f inside {'h00, 'h02, 'h03, 'h1C, 'h1D}) begin rsv = 0; sh = 32'(imm) % 32; end
      if (f == 'h08) begin rtv = 0; rdv = 0; end
      if (f == 'h09) rtv = 0;
      w = rsv * (1 << 21) + rtv * (1 << 16) + rdv * (1 << 11) + sh * 64 + 32'(f);
    end else if (op == 'h02 || op == 'h03) begin
      ok = 1;
      w = 32'(op) * (1 << 26) + 32'(tg);
    end else begin
      ok = op inside {'h08, 'h0C, 'h0D, 'h0E, 'h0A, 'h0B, 'h0F, 'h23, 'h2B, 'h04, 'h05, 'h01, 'h07};
      if (op == 'h0F) rsv = 0;
      if (op == 'h01 || op == 'h07) rtv = 0;
      w = 32'(op) * (1 << 26) + rsv * (1 << 21) + rtv * (1 << 16) + 32'(imm);
    end
    return ok ? {1'b0, w} : {1'b1, 32'h0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    bit v = m_q.size() != 0;
    check("out_valid", 64'(out_valid), 64'(v));
    check("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
    check("out_word", 64'(out_word), v ? 64'(m_q[0][31:0]) : 64'h0);
    check("out_err", 64'(out_err), v ? 64'(m_q[0][32]) : 64'h0);
    check("enc_count", 64'(enc_count), 64'(m_count));
    check("err_seen", 64'(err_seen), 64'(m_err_seen));
  endtask

  // drive after the falling edge, update the model at the rising edge, compare at the next falling edge
  task automatic cycle(input logic v, input logic [5:0] op, f, input logic [4:0] rs, rt, rd,
                       input logic [15:0] imm, input logic [25:0] tg, input logic ordy,
                       input logic rstn);
    bit acc, pop;
    rst_n = rstn; in_valid = v; in_opcode = op; in_funct = f;
    in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tg; out_ready = ordy;
    @(posedge clk);
    if (!rstn) begin
      m_q.delete(); m_count = 0; m_err_seen = 0;
    end else begin
      acc = v && m_q.size() < 2;
      pop = m_q.size() != 0 && ordy;
      if (pop) begin void'(m_q.pop_front()); m_count = (m_count + 1) % 65536; end
      if (acc) begin
        m_q.push_back(ref_enc(op, f, rs, rt, rd, imm, tg));
        if (m_q[$][32]) m_err_seen = 1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 6'h0, 6'h0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, ordy, 1'b1);
  endtask

  initial begin
    int guard;
    @(negedge clk);
    cycle(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b0);
    cycle(1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b0);
    check("reset_in_ready", 64'(in_ready), 64'h1);
    check("reset_out_valid", 64'(out_valid), 64'h0);
    // add
    cycle(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1);
    check("add_word", 64'(out_word), 64'h00221820);
    check("add_err", 64'(out_err), 64'h0);
    idle(1'b1);
    // sll with rs forced to zero
    cycle(1'b1, 6'h00, 6'h00, 5'd5, 5'd2, 5'd4, 16'h0003, 26'h0, 1'b0, 1'b1);
    check("sll_word", 64'(out_word), 64'h000220C0);
    idle(1'b1);
    // lw then j with consumer stalled, third request refused
    cycle(1'b1, 6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 16'hFFFC, 26'h0, 1'b0, 1'b1);
    cycle(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100, 1'b0, 1'b1);
    check("full_in_ready", 64'(in_ready), 64'h0);
    check("lw_word", 64'(out_word), 64'h8FA8FFFC);
    cycle(1'b1, 6'h00, 6'h20, 5'd7, 5'd7, 5'd7, 16'h0, 26'h0, 1'b0, 1'b1);
    check("stall_hold", 64'(out_word), 64'h8FA8FFFC);
    idle(1'b1);
    check("j_word", 64'(out_word), 64'h08000100);
    idle(1'b1);
    // illegal opcode and crypt functs
    cycle(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b0, 1'b1);
    check("ill_word", 64'(out_word), 64'h0);
    check("ill_err", 64'(out_err), 64'h1);
    idle(1'b1);
    check("err_sticky", 64'(err_seen), 64'h1);
    cycle(1'b1, 6'h00, 6'h30, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1);
`ifdef MIPS_CRYPT_EN
    check("crypt_word", 64'(out_word), 64'h00221830);
`else
    check("crypt_err", 64'(out_err), 64'h1);
`endif
    idle(1'b1);
    cycle(1'b1, 6'h00, 6'h31, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, 1'b1);
    idle(1'b1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
      cycle(1'($urandom), op, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 26'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
    end
    // stream until the handshake counter wraps
    guard = 0;
    do begin
      cycle(1'b1, 6'h0D, 6'h00, 5'd3, 5'd4, 5'd0, 16'hBEEF, 26'h0, 1'b1, 1'b1);
      guard++;
    end while (m_count != 0 && guard < 70000);
    check("wrap_guard", 64'(guard < 70000), 64'h1);
    check("wrap_count", 64'(enc_count), 64'h0);
    // reset with two buffered words
    idle(1'b0);
    cycle(1'b1, 6'h08, 6'h00, 5'd1, 5'd1, 5'd0, 16'h0001, 26'h0, 1'b0, 1'b1);
    cycle(1'b1, 6'h08, 6'h00, 5'd2, 5'd2, 5'd0, 16'h0002, 26'h0, 1'b0, 1'b1);
    check("pre_rst_full", 64'(in_ready), 64'h0);
    cycle(1'b1, 6'h08, 6'h00, 5'd3, 5'd3, 5'd0, 16'h0003, 26'h0, 1'b1, 1'b0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_enc_count", 64'(enc_count), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    idle(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
